// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and port/owner identifiers.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational winner select between port C and port D.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port C has fixed priority.
module dmem_arb_grant
    import dmem_port_arbiter_pkg::*;
(
    input  logic      c_req,
    input  logic      d_req,
`ifdef DMEM_ARB_RR_EN
    input  arb_port_t last_grant,
`endif
    output logic      grant_valid,
    output arb_port_t grant
);

    always_comb begin
        grant_valid = c_req | d_req;
        grant       = PORT_C;
`ifdef DMEM_ARB_RR_EN
        // On a tie the port that did not win last time goes first.
        if (c_req && d_req) begin
            grant = (last_grant == PORT_C) ? PORT_D : PORT_C;
        end else if (d_req) begin
            grant = PORT_D;
        end
`else
        if (!c_req && d_req) begin
            grant = PORT_D;
        end
`endif
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises port C (load/store stage) and port D (debug/loader) onto one single-port data RAM.
// Define DMEM_ARB_RR_EN for round-robin ties; default build gives port C fixed priority.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LAT - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    arb_port_t     owner;
    arb_port_t     grant;
    logic          grant_valid;
    logic [CW-1:0] lat_cnt;

`ifdef DMEM_ARB_RR_EN
    arb_port_t     last_grant;
`endif

    dmem_arb_grant u_grant (
        .c_req       (c_req),
        .d_req       (d_req),
`ifdef DMEM_ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM request is frozen at grant time so the requesters' buses may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= PORT_C;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            lat_cnt <= '0;
            c_rdata <= '0;
            d_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= PORT_D;
`endif
        end else begin
            if (state == IDLE && grant_valid) begin
                owner <= grant;
`ifdef DMEM_ARB_RR_EN
                last_grant <= grant;
`endif
                if (grant == PORT_D) begin
                    m_we    <= d_we;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    m_we    <= c_we;
                    m_addr  <= c_addr;
                    m_wdata <= c_wdata;
                end
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_LAST;
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            // Only the owner's read-data register moves; the other port keeps its old word.
            if (state == WAIT && lat_cnt == '0) begin
                if (owner == PORT_D) begin
                    d_rdata <= m_rdata;
                end else begin
                    c_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en    = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign c_ack   = (state == RESP) && (owner == PORT_C);
    assign d_ack   = (state == RESP) && (owner == PORT_D);
    assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model. Honours DMEM_ARB_RR_EN; set RAM_LAT to exercise longer RAM latency.
module tb_dmem_port_arbiter;

    parameter int RAM_LAT = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_ack, c_stall;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_en, m_we, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(RAM_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_ack   (c_ack),
        .c_stall (c_stall),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    // RAM environment: 256 words, read data appears RAM_LAT cycles after m_en, noise otherwise.
    logic        ram_init;
    logic [31:0] ram [256];
    logic [31:0] pipe [RAM_LAT];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (m_en && m_we) begin
            ram[m_addr[7:0]] <= m_wdata;
        end
        pipe[0] <= m_en ? ram[m_addr[7:0]] : $urandom;
        for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata = pipe[RAM_LAT-1];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          patience;
        bit          drop_after_grant;
        bit          granted;
    } txn_t;

    txn_t q_c[$];
    txn_t q_d[$];

    // Transaction-level reference: grant cycle, owner, request and the word a read must return.
    logic [31:0] ref_mem [256];
    int          cyc;
    int          g_cyc = -100;
    int          next_idle = 0;
    logic        g_port, g_we;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic        last_port = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int patience, input bit drop);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        t.patience = patience; t.drop_after_grant = drop; t.granted = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int pat;
        pat = ($urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : -1;
        return mk(1'($urandom_range(1)), 32'($urandom_range(31)) + 32'd64, $urandom, pat,
                  $urandom_range(15) == 0);
    endfunction

    task automatic agent_eval(input txn_t h, input logic ack, output bit pop, output txn_t nh);
        pop = 1'b0;
        nh  = h;
        if (h.granted && (ack || h.drop_after_grant)) begin
            pop = 1'b1;
        end else if (!h.granted && h.patience > 0) begin
            nh.patience = h.patience - 1;
            if (nh.patience == 0) pop = 1'b1;
        end
    endtask

    task automatic apply_stimulus();
        c_req = (q_c.size() > 0);
        d_req = (q_d.size() > 0);
        if (c_req) begin
            c_we = q_c[0].we; c_addr = q_c[0].addr; c_wdata = q_c[0].wdata;
        end else begin
            c_we = 1'b0; c_addr = $urandom; c_wdata = $urandom;
        end
        if (d_req) begin
            d_we = q_d[0].we; d_addr = q_d[0].addr; d_wdata = q_d[0].wdata;
        end else begin
            d_we = 1'b0; d_addr = $urandom; d_wdata = $urandom;
        end
    endtask

    // One clock: compare this cycle's outputs, let requesters react, drive, then model arbitration.
    task automatic step();
        logic en_e, ack_e, busy_e, win;
        bit   pop;
        txn_t nh;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        en_e   = (cyc == g_cyc + 1);
        ack_e  = (cyc == g_cyc + 2 + RAM_LAT);
        busy_e = (cyc > g_cyc) && (cyc <= g_cyc + 2 + RAM_LAT);
        check_output("m_en", 32'(m_en), 32'(en_e));
        check_output("busy", 32'(busy), 32'(busy_e));
        check_output("c_ack", 32'(c_ack), 32'(ack_e && g_port == 1'b0));
        check_output("d_ack", 32'(d_ack), 32'(ack_e && g_port == 1'b1));
        check_output("c_stall", 32'(c_stall), 32'(c_req && !(ack_e && g_port == 1'b0)));
        if (en_e) begin
            check_output("m_we", 32'(m_we), 32'(g_we));
            check_output("m_addr", m_addr, g_addr);
            if (g_we) check_output("m_wdata", m_wdata, g_wdata);
        end
        if (ack_e && !g_we) begin
            if (g_port == 1'b0) check_output("c_rdata", c_rdata, g_rdata);
            else                check_output("d_rdata", d_rdata, g_rdata);
        end

        if (q_c.size() > 0) begin
            agent_eval(q_c[0], c_ack, pop, nh);
            if (pop) void'(q_c.pop_front());
            else     q_c[0] = nh;
        end
        if (q_d.size() > 0) begin
            agent_eval(q_d[0], d_ack, pop, nh);
            if (pop) void'(q_d.pop_front());
            else     q_d[0] = nh;
        end
        apply_stimulus();

        if (cyc >= next_idle && (c_req || d_req)) begin
`ifdef DMEM_ARB_RR_EN
            win = (c_req && d_req) ? ~last_port : d_req;
`else
            win = ~c_req;
`endif
            if (win == 1'b0) begin
                g_we = q_c[0].we; g_addr = q_c[0].addr; g_wdata = q_c[0].wdata;
                q_c[0].granted = 1'b1;
            end else begin
                g_we = q_d[0].we; g_addr = q_d[0].addr; g_wdata = q_d[0].wdata;
                q_d[0].granted = 1'b1;
            end
            g_port  = win;
            g_rdata = ref_mem[g_addr[7:0]];
            if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
            last_port = win;
            g_cyc     = cyc;
            next_idle = cyc + 3 + RAM_LAT;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_c.size() > 0 || q_d.size() > 0 || cyc < next_idle) && n < 400) begin
            step();
            n++;
        end
        check_output({tag, "_drain"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1; cyc = 0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        @(negedge clk);
        check_output("rst_m_en", 32'(m_en), 32'd0);
        check_output("rst_m_we", 32'(m_we), 32'd0);
        check_output("rst_m_addr", m_addr, 32'd0);
        check_output("rst_m_wdata", m_wdata, 32'd0);
        check_output("rst_c_ack", 32'(c_ack), 32'd0);
        check_output("rst_d_ack", 32'(d_ack), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_c_rdata", c_rdata, 32'd0);
        check_output("rst_d_rdata", d_rdata, 32'd0);
        check_output("rst_c_stall", 32'(c_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0; ram_init = 1'b0;
        $display("[TB] reset released, RAM_LAT=%0d", RAM_LAT);
        repeat (6) step();

        $display("[TB] port C write then read of word 84");
        q_c.push_back(mk(1'b1, 32'd84, 32'hDEAD_BEEF, -1, 1'b0));
        drain("c_write");
        q_c.push_back(mk(1'b0, 32'd84, 32'h0, -1, 1'b0));
        drain("c_read");

        $display("[TB] simultaneous requests");
        q_c.push_back(mk(1'b0, 32'd80, 32'h0, -1, 1'b0));
        q_d.push_back(mk(1'b0, 32'd84, 32'h0, -1, 1'b0));
        drain("tie");

        $display("[TB] port C back-to-back against port D");
        for (int i = 0; i < 6; i++) q_c.push_back(mk(1'b0, 32'(64 + i), 32'h0, -1, 1'b0));
        q_d.push_back(mk(1'b1, 32'd80, 32'h1234_5678, -1, 1'b0));
        drain("hog");

        $display("[TB] owner drops request after grant, port D withdraws before grant");
        q_c.push_back(mk(1'b0, 32'd80, 32'h0, -1, 1'b1));
        drain("drop_after");
        q_c.push_back(mk(1'b0, 32'd84, 32'h0, -1, 1'b0));
        step();
        q_d.push_back(mk(1'b1, 32'd84, 32'hBAD0_BAD0, 2, 1'b0));
        drain("withdraw");

        $display("[TB] reset during WAIT");
        q_c.push_back(mk(1'b0, 32'd84, 32'h0, -1, 1'b0));
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        q_c.delete(); q_d.delete();
        c_req = 1'b0; d_req = 1'b0;
        #1;
        check_output("midrst_m_en", 32'(m_en), 32'd0);
        check_output("midrst_c_ack", 32'(c_ack), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        g_cyc = -100; next_idle = 0; last_port = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();
        q_c.push_back(mk(1'b0, 32'd84, 32'h0, -1, 1'b0));
        drain("post_rst");

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if (q_c.size() == 0 && $urandom_range(3) == 0) q_c.push_back(rand_txn());
            if (q_d.size() == 0 && $urandom_range(3) == 0) q_d.push_back(rand_txn());
            step();
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
